// File: rtl/cache_line_axi_master.sv
// Moves one cache line between the cache and memory as single-beat AXI4-Lite transfers.
// Define CACHE_AXI_RESP_CHECK_EN to add the sticky o_resp_err flag for non-OKAY responses.
module cache_line_axi_master #(
    parameter int unsigned AXI_ADDR_W  = 64,
    parameter int unsigned AXI_DATA_W  = 32,
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic                              i_clk,
    input  logic                              i_arst,
    input  logic                              i_read_start,
    input  logic                              i_write_start,
    input  logic [AXI_ADDR_W-1:0]             i_addr,
    input  logic [BLOCK_WORDS*AXI_DATA_W-1:0] i_wline,
    output logic [BLOCK_WORDS*AXI_DATA_W-1:0] o_rline,
    output logic                              o_done,
    output logic                              o_busy,
`ifdef CACHE_AXI_RESP_CHECK_EN
    output logic                              o_resp_err,
`endif
    output logic [AXI_ADDR_W-1:0]             o_araddr,
    output logic                              o_arvalid,
    output logic                              o_rready,
    output logic [AXI_ADDR_W-1:0]             o_awaddr,
    output logic                              o_awvalid,
    output logic [AXI_DATA_W-1:0]             o_wdata,
    output logic [AXI_DATA_W/8-1:0]           o_wstrb,
    output logic                              o_wvalid,
    output logic                              o_bready,
    input  logic                              i_arready,
    input  logic                              i_rvalid,
    input  logic [AXI_DATA_W-1:0]             i_rdata,
    input  logic [1:0]                        i_rresp,
    input  logic                              i_awready,
    input  logic                              i_wready,
    input  logic                              i_bvalid,
    input  logic [1:0]                        i_bresp
);

    localparam int unsigned CNT_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W  = CNT_W + 2;
    localparam int unsigned HI_W   = AXI_ADDR_W - OFF_W;
    localparam int unsigned LINE_W = BLOCK_WORDS * AXI_DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t           state;
    logic [HI_W-1:0]  base_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last_word;
    logic             aw_ok;
    logic             w_ok;
    logic             aw_hs;
    logic             w_hs;

    assign cnt_nxt   = cnt + CNT_W'(1);
    assign last_word = (cnt == CNT_W'(BLOCK_WORDS - 1));
    assign aw_hs     = o_awvalid & i_awready;
    assign w_hs      = o_wvalid & i_wready;

    // Word address stays inside the line: index/tag bits never see a carry.
    function automatic logic [AXI_ADDR_W-1:0] word_addr(input logic [HI_W-1:0] hi,
                                                         input logic [CNT_W-1:0] idx);
        return {hi, idx, 2'b00};
    endfunction

    function automatic logic [AXI_DATA_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                         input logic [CNT_W-1:0] idx);
        return line[AXI_DATA_W*int'(idx) +: AXI_DATA_W];
    endfunction

`ifdef CACHE_AXI_RESP_CHECK_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, i_addr[OFF_W-1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, i_addr[OFF_W-1:0], i_rresp, i_bresp};
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state     <= IDLE;
            base_q    <= '0;
            cnt       <= '0;
            aw_ok     <= 1'b0;
            w_ok      <= 1'b0;
            o_rline   <= '0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_araddr  <= '0;
            o_arvalid <= 1'b0;
            o_rready  <= 1'b0;
            o_awaddr  <= '0;
            o_awvalid <= 1'b0;
            o_wdata   <= '0;
            o_wstrb   <= '0;
            o_wvalid  <= 1'b0;
            o_bready  <= 1'b0;
`ifdef CACHE_AXI_RESP_CHECK_EN
            o_resp_err <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    base_q <= i_addr[AXI_ADDR_W-1:OFF_W];
                    cnt    <= '0;
                    aw_ok  <= 1'b0;
                    w_ok   <= 1'b0;
                    // Write-back has priority over allocate when both are requested.
                    if (i_write_start) begin
                        state     <= WR_REQ;
                        o_busy    <= 1'b1;
                        o_awvalid <= 1'b1;
                        o_wvalid  <= 1'b1;
                        o_awaddr  <= word_addr(i_addr[AXI_ADDR_W-1:OFF_W], '0);
                        o_wdata   <= line_word(i_wline, '0);
                        o_wstrb   <= '1;
`ifdef CACHE_AXI_RESP_CHECK_EN
                        o_resp_err <= 1'b0;
`endif
                    end else if (i_read_start) begin
                        state     <= RD_ADDR;
                        o_busy    <= 1'b1;
                        o_arvalid <= 1'b1;
                        o_araddr  <= word_addr(i_addr[AXI_ADDR_W-1:OFF_W], '0);
`ifdef CACHE_AXI_RESP_CHECK_EN
                        o_resp_err <= 1'b0;
`endif
                    end
                end

                RD_ADDR: begin
                    if (i_arready) begin
                        state     <= RD_DATA;
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                    end
                end

                RD_DATA: begin
                    if (i_rvalid) begin
                        o_rline[AXI_DATA_W*int'(cnt) +: AXI_DATA_W] <= i_rdata;
                        o_rready <= 1'b0;
`ifdef CACHE_AXI_RESP_CHECK_EN
                        if (i_rresp != 2'b00) o_resp_err <= 1'b1;
`endif
                        if (last_word) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            cnt       <= cnt_nxt;
                            o_arvalid <= 1'b1;
                            o_araddr  <= word_addr(base_q, cnt_nxt);
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W complete independently; sticky flags remember each side.
                    if (aw_hs) begin
                        o_awvalid <= 1'b0;
                        aw_ok     <= 1'b1;
                    end
                    if (w_hs) begin
                        o_wvalid <= 1'b0;
                        w_ok     <= 1'b1;
                    end
                    if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                        state    <= WR_RESP;
                        o_bready <= 1'b1;
                    end
                end

                WR_RESP: begin
                    if (i_bvalid) begin
                        o_bready <= 1'b0;
`ifdef CACHE_AXI_RESP_CHECK_EN
                        if (i_bresp != 2'b00) o_resp_err <= 1'b1;
`endif
                        if (last_word) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= WR_REQ;
                            cnt       <= cnt_nxt;
                            aw_ok     <= 1'b0;
                            w_ok      <= 1'b0;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            o_awaddr  <= word_addr(base_q, cnt_nxt);
                            o_wdata   <= line_word(i_wline, cnt_nxt);
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_line_axi_master.md
# cache_line_axi_master

Multi-beat line mover between the cache controller and main memory over AXI4-Lite. On a start request from the cache FSM it moves one whole cache line as a sequence of single-beat AXI4-Lite transactions, one per 32-bit word: reads for instruction or data allocate, writes for dirty-line write-back. It raises a one-cycle done pulse that the cache FSM samples to leave its ALLOCATE_I, ALLOCATE_D or WRITE_BACK state. Read data is returned as a full line for the cache write port.

## Interface
- AXI_ADDR_W, 64, AXI address width.
- AXI_DATA_W, 32, beat width; fixed at 32.
- BLOCK_WORDS, 16, words per cache line; power of two, at least 2.
- i_clk  in  1  clock.
- i_arst  in  1  reset, asynchronous, active-high.
- i_read_start  in  1  line read request (OR of the FSM's read_start_i/read_start_d); level, held until o_done.
- i_write_start  in  1  line write request; level, held until o_done.
- i_addr  in  AXI_ADDR_W  line base address; low log2(BLOCK_WORDS)+2 bits are ignored and forced to 0.
- i_wline  in  BLOCK_WORDS*32  line to write; word k sits at bits [32k+31:32k].
- o_rline  out  BLOCK_WORDS*32  assembled read line, same packing.
- o_done  out  1  one-cycle completion pulse.
- o_busy  out  1  transfer in progress.
- AXI master outputs: o_araddr (AXI_ADDR_W), o_arvalid, o_rready, o_awaddr (AXI_ADDR_W), o_awvalid, o_wdata (32), o_wstrb (4), o_wvalid, o_bready.
- AXI master inputs: i_arready, i_rvalid, i_rdata (32), i_rresp (2), i_awready, i_wready, i_bvalid, i_bresp (2).

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - Latch the aligned base into base_q.
  - Clear word counter cnt, which is log2(BLOCK_WORDS) bits wide.
  - i_write_start goes to WR_REQ. Otherwise i_read_start goes to RD_ADDR.
  - If both are asserted together, write wins.
- RD_ADDR:
  - o_arvalid=1, o_araddr=base_q+4*cnt.
  - On i_arready go to RD_DATA.
- RD_DATA:
  - o_rready=1.
  - On i_rvalid, write i_rdata into word cnt of the line buffer.
  - If cnt is the last word, go to DONE; otherwise increment cnt and return to RD_ADDR.
- WR_REQ:
  - Assert o_awvalid and o_wvalid together, with o_awaddr=base_q+4*cnt, o_wdata=word cnt of i_wline, and o_wstrb=4'hF.
  - Drop each valid independently once its ready has been seen, tracked by sticky flags aw_ok and w_ok.
  - Leave when both handshakes are complete. This may happen in the same cycle.
- WR_RESP:
  - o_bready=1.
  - On i_bvalid, if cnt is the last word go to DONE; otherwise increment cnt, clear the flags and return to WR_REQ.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE.
  - A start still high in the cycle after DONE is treated as a new request. The cache FSM must drop its start combinationally on o_done.
- o_busy=1 in every state except IDLE.
- i_wline and i_addr are sampled live after the start: i_addr is latched at start, and i_wline must be held stable until o_done.
- o_rline is held between transfers and is only updated by read beats.
- Address arithmetic: cnt*4 is added within the line offset only, with no carry into the index or tag bits. The last word is base_q+4*(BLOCK_WORDS-1).

## Timing
- Reset values: state IDLE, cnt 0, all AXI valid and ready outputs 0, o_done 0, o_busy 0, o_rline 0, addresses 0, o_wdata 0, o_wstrb 0.
- All outputs are registered or decoded from state only. No AXI output depends combinationally on an AXI input.
- Minimum read latency with zero-wait slaves: 2 cycles per word, plus 1 DONE cycle, plus 1 IDLE cycle. With BLOCK_WORDS=16 a line read takes 34 cycles from start to o_done.
- Minimum write latency: same, 2 cycles per word.
- AXI rules:
  - A valid, once asserted, is held with stable address and data until its ready is seen.
  - The ready outputs are asserted only in their waiting states.
- i_arst mid-transfer: return to IDLE immediately and deassert all valids. An outstanding slave response is then ignored. The system resets the slave together with the master.

## Configuration
- CACHE_AXI_RESP_CHECK_EN defined:
  - Adds output o_resp_err (1 bit, reset 0).
  - It is set if any i_rresp or i_bresp sampled on a handshake is non-zero (SLVERR or DECERR), and is sticky until the next start in IDLE.
  - The transfer still completes all beats.
- Macro undefined:
  - o_resp_err is absent and the resp inputs are ignored.

## Test plan
- Zero-wait line read, base 0x1000_0040, slave returns 0xA000_0000+k for word k -> ARADDR 0x1000_0040..0x1000_007C in order, o_rline word 15 = 0xA000_000F, o_done single pulse at cycle 34.
- Line write with i_awready delayed 3 cycles and i_wready immediate -> o_wvalid drops after 1 cycle, o_awvalid held with a stable address, exactly 16 B handshakes, then o_done.
- i_read_start and i_write_start asserted in the same cycle (write-back followed by allocate sequence) -> write completes first, o_done; then a new read starts on the next start, with 0 AR beats during the write.
- Unaligned i_addr 0x1000_0047 -> first ARADDR 0x1000_0040.
- i_arst asserted mid-read at word 5 -> all valids 0 in the same cycle, o_busy 0, and a fresh read after release starts at word 0.
- With CACHE_AXI_RESP_CHECK_EN defined, i_rresp=2'b10 on word 3 -> o_resp_err=1 at o_done, all 16 beats issued, cleared on the next start.
